// File: rtl/bench_report_pkg.sv
// Shared constants and helpers for the benchmark result reporter:
// line geometry, ASCII codes, hex-digit conversion and baud divisor math.
package bench_report_pkg;

    localparam int LINE_LEN = 82;
    localparam logic [6:0] LAST_IDX = 7'(LINE_LEN - 1);

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_N    = 8'h4E;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FINISH
    } line_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

    // Rounded-to-nearest clocks per bit.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for baud_div(CLK_HZ, BAUD) cycles; tx_done pulses once per byte.
module uart_tx_8n1 #(
    parameter int unsigned CLK_HZ = 125000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    import bench_report_pkg::*;

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
    localparam int DIV_W = $clog2(DIV + 1);

    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic [8:0]       r_shift;
    logic [3:0]       r_bitCnt;
    logic [DIV_W-1:0] r_divCnt;

    // r_shift holds the remaining data bits with the stop bit parked at the top.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_divCnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (tx_start) begin
                    r_busy   <= 1'b1;
                    r_shift  <= {1'b1, tx_data};
                    r_tx     <= 1'b0;
                    r_bitCnt <= '0;
                    r_divCnt <= '0;
                end
            end else if (r_divCnt == DIV_W'(DIV - 1)) begin
                r_divCnt <= '0;
                if (r_bitCnt == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_tx     <= r_shift[0];
                    r_shift  <= {1'b1, r_shift[8:1]};
                    r_bitCnt <= r_bitCnt + 4'd1;
                end
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: rtl/bench_result_uart.sv
// Snapshots bench_engine results on each rising edge of done and sends them
// as one 82-character ASCII line over an 8N1 UART.
module bench_result_uart #(
    parameter int unsigned CLK_HZ = 125000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [1:0]  winner_code,
    input  logic [31:0] t_cond0,
    input  logic [31:0] t_cond1,
    input  logic [31:0] t_cond2,
    input  logic [31:0] t_cond3,
    input  logic [31:0] t_total,
    input  logic [31:0] t_runtime,
    input  logic [15:0] ops_per_condition,
    output logic        uart_tx,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frames_sent
);
    import bench_report_pkg::*;

    line_state_t r_state;
    line_state_t w_stateNext;
    logic        r_doneD;
    logic [6:0]  r_charIdx;
    logic        r_overrun;
    logic [7:0]  r_frames;
    logic [1:0]  r_winner;
    logic [31:0] r_cond0, r_cond1, r_cond2, r_cond3, r_total, r_runtime;
    logic [15:0] r_ops;

    logic        w_doneRise;
    logic        w_txStart;
    logic        w_txBusy;
    logic        w_txDone;
    logic [7:0]  w_char;
    logic [31:0] w_hexWord;
    logic [6:0]  w_hexBase;
    logic [6:0]  w_hexOff;
    logic [3:0]  w_nibble;
    logic        w_isHex;

    assign w_doneRise = done & ~r_doneD;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_doneD   <= 1'b0;
            r_charIdx <= '0;
            r_overrun <= 1'b0;
            r_frames  <= '0;
            r_winner  <= '0;
            r_cond0   <= '0;
            r_cond1   <= '0;
            r_cond2   <= '0;
            r_cond3   <= '0;
            r_total   <= '0;
            r_runtime <= '0;
            r_ops     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_doneD <= done;
            // Any edge outside IDLE (including the FINISH cycle) is an overrun.
            if (w_doneRise) begin
                if (r_state == ST_IDLE) begin
                    r_winner  <= winner_code;
                    r_cond0   <= t_cond0;
                    r_cond1   <= t_cond1;
                    r_cond2   <= t_cond2;
                    r_cond3   <= t_cond3;
                    r_total   <= t_total;
                    r_runtime <= t_runtime;
                    r_ops     <= ops_per_condition;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (r_state == ST_SEND && w_txDone && r_charIdx != LAST_IDX)
                r_charIdx <= r_charIdx + 7'd1;
            if (r_state == ST_FINISH) begin
                r_frames  <= r_frames + 8'd1;
                r_charIdx <= '0;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_txStart   = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_doneRise) w_stateNext = ST_LOAD;
            ST_LOAD: begin
                if (!w_txBusy) begin
                    w_txStart   = 1'b1;
                    w_stateNext = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_txDone)
                    w_stateNext = (r_charIdx == LAST_IDX) ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_IDLE;
        endcase
    end

    // Hex fields are picked by character offset from the field start, MSB nibble first.
    always_comb begin
        w_hexWord = '0;
        w_hexBase = '0;
        w_isHex   = 1'b1;
        if (r_charIdx >= 7'd7 && r_charIdx <= 7'd14) begin
            w_hexWord = r_cond0;   w_hexBase = 7'd7;
        end else if (r_charIdx >= 7'd19 && r_charIdx <= 7'd26) begin
            w_hexWord = r_cond1;   w_hexBase = 7'd19;
        end else if (r_charIdx >= 7'd31 && r_charIdx <= 7'd38) begin
            w_hexWord = r_cond2;   w_hexBase = 7'd31;
        end else if (r_charIdx >= 7'd43 && r_charIdx <= 7'd50) begin
            w_hexWord = r_cond3;   w_hexBase = 7'd43;
        end else if (r_charIdx >= 7'd54 && r_charIdx <= 7'd61) begin
            w_hexWord = r_total;   w_hexBase = 7'd54;
        end else if (r_charIdx >= 7'd65 && r_charIdx <= 7'd72) begin
            w_hexWord = r_runtime; w_hexBase = 7'd65;
        end else if (r_charIdx >= 7'd76 && r_charIdx <= 7'd79) begin
            w_hexWord = {r_ops, 16'h0000}; w_hexBase = 7'd76;
        end else begin
            w_isHex = 1'b0;
        end

        w_hexOff = r_charIdx - w_hexBase;
        w_nibble = '0;
        for (int k = 0; k < 8; k++)
            if (w_hexOff == 7'(k)) w_nibble = w_hexWord[31-4*k -: 4];

        w_char = ASCII_SP;
        if (w_isHex) begin
            w_char = hex_ascii(w_nibble);
        end else begin
            case (r_charIdx)
                7'd0:                                        w_char = ASCII_W;
                7'd1, 7'd6, 7'd18, 7'd30, 7'd42, 7'd53,
                7'd64, 7'd75:                                w_char = ASCII_EQ;
                7'd2:  w_char = ASCII_ZERO + {6'd0, r_winner};
                7'd4, 7'd16, 7'd28, 7'd40:                   w_char = ASCII_C;
                7'd5:  w_char = ASCII_ZERO;
                7'd17: w_char = ASCII_ZERO + 8'd1;
                7'd29: w_char = ASCII_ZERO + 8'd2;
                7'd41: w_char = ASCII_ZERO + 8'd3;
                7'd52: w_char = ASCII_T;
                7'd63: w_char = ASCII_R;
                7'd74: w_char = ASCII_N;
                7'd80: w_char = ASCII_CR;
                7'd81: w_char = ASCII_LF;
                default:                                     w_char = ASCII_SP;
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tx (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .tx_start (w_txStart),
        .tx_data  (w_char),
        .tx       (uart_tx),
        .tx_busy  (w_txBusy),
        .tx_done  (w_txDone)
    );

    assign busy        = (r_state != ST_IDLE);
    assign overrun     = r_overrun;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_bench_result_uart.sv
// Directed bench for bench_result_uart at 10 clocks per bit; a host-side
// UART receiver decodes each line and compares it with hand-written text.
module tb_bench_result_uart;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned BAUD   = 100;
    localparam int DIV = 10;

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic [1:0]  winner_code;
    logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3, t_total, t_runtime;
    logic [15:0] ops_per_condition;
    logic        uart_tx, busy, overrun;
    logic [7:0]  frames_sent;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bench_result_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sysclk            (sysclk),
        .rst_n             (rst_n),
        .done              (done),
        .winner_code       (winner_code),
        .t_cond0           (t_cond0),
        .t_cond1           (t_cond1),
        .t_cond2           (t_cond2),
        .t_cond3           (t_cond3),
        .t_total           (t_total),
        .t_runtime         (t_runtime),
        .ops_per_condition (ops_per_condition),
        .uart_tx           (uart_tx),
        .busy              (busy),
        .overrun           (overrun),
        .frames_sent       (frames_sent)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [1:0] w, input logic [31:0] c0, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [31:0] c3, input logic [31:0] tot,
                                 input logic [31:0] run, input logic [15:0] ops);
        winner_code = w;
        t_cond0 = c0; t_cond1 = c1; t_cond2 = c2; t_cond3 = c3;
        t_total = tot; t_runtime = run; ops_per_condition = ops;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int value, input int lo, input int hi);
        checks++;
        assert (value >= lo && value <= hi) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, value, lo, hi);
        end
    endtask

    task automatic checkLine(input string tag, input string observed, input string expected);
        checks++;
        assert (observed == expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=\"%s\" expected=\"%s\"", tag, observed, expected);
        end
    endtask

    function automatic string mkLine(input string body);
        return $sformatf("%s%c%c", body, 8'h0D, 8'h0A);
    endfunction

    // Host receiver: find the start bit, then sample every bit at its centre.
    task automatic rxByte(output logic [7:0] b, output bit ok, output int startCyc);
        int waitCnt = 0;
        ok = 1'b1;
        b = '0;
        startCyc = 0;
        @(negedge sysclk);
        while (uart_tx !== 1'b0 && waitCnt < 3000) begin
            @(negedge sysclk);
            waitCnt++;
        end
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        startCyc = cyc;
        repeat (DIV / 2) @(negedge sysclk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge sysclk);
            b[i] = uart_tx;
        end
        repeat (DIV) @(negedge sysclk);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic rxLine(output string s, output int startCyc);
        logic [7:0] b;
        bit ok;
        bit allOk = 1'b1;
        int t;
        s = "";
        startCyc = 0;
        for (int i = 0; i < 82; i++) begin
            rxByte(b, ok, t);
            if (i == 0) startCyc = t;
            if (!ok) begin
                allOk = 1'b0;
                break;
            end
            s = $sformatf("%s%c", s, b);
        end
        checkOutput("rx_framing", 64'(allOk), 64'd1);
    endtask

    task automatic waitBusyLow(output int fallCyc);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        fallCyc = cyc;
        checkOutput("busy_fall", 64'(busy), 64'd0);
    endtask

    task automatic applyReset();
        done  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic countTxLow(input int nCycles, output int lows);
        lows = 0;
        repeat (nCycles) begin
            @(negedge sysclk);
            if (uart_tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        string line;
        string line2  = mkLine("W=2 C0=00000010 C1=00000020 C2=0000000F C3=DEADBEEF T=12345678 R=0000ABCD N=0400");
        string line3  = mkLine("W=1 C0=00000000 C1=FFFFFFFF C2=89ABCDEF C3=01234567 T=A5A5A5A5 R=00000001 N=FFFF");
        string line4  = mkLine("W=3 C0=11111111 C1=22222222 C2=33333333 C3=44444444 T=55555555 R=66666666 N=7777");
        int startCyc, fallCyc, lows, raiseCyc, n;

        // 1: reset and idle
        applyStimulus(2'd0, 0, 0, 0, 0, 0, 0, 16'h0);
        applyReset();
        repeat (500) @(negedge sysclk);
        checkOutput("idle_tx", 64'(uart_tx), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_overrun", 64'(overrun), 64'd0);
        checkOutput("idle_frames", 64'(frames_sent), 64'd0);

        // 2: one full line, timing and busy
        applyStimulus(2'd2, 32'h00000010, 32'h00000020, 32'h0000000F, 32'hDEADBEEF,
                      32'h12345678, 32'h0000ABCD, 16'h0400);
        done = 1'b1;
        fork
            rxLine(line, startCyc);
            begin
                @(negedge sysclk);
                checkOutput("busy_after_capture", 64'(busy), 64'd1);
            end
        join
        waitBusyLow(fallCyc);
        checkLine("line_basic", line, line2);
        checkRange("line_duration", fallCyc - startCyc, 8200, 8364);
        checkOutput("frames_after_first", 64'(frames_sent), 64'd1);
        done = 1'b0;
        repeat (5) @(negedge sysclk);

        // 3: inputs change after capture
        applyStimulus(2'd1, 32'h00000000, 32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567,
                      32'hA5A5A5A5, 32'h00000001, 16'hFFFF);
        done = 1'b1;
        fork
            rxLine(line, startCyc);
            begin
                repeat (5) @(negedge sysclk);
                applyStimulus(2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h1234);
                done = 1'b0;
            end
        join
        waitBusyLow(fallCyc);
        checkLine("line_snapshot_held", line, line3);
        checkOutput("frames_after_second", 64'(frames_sent), 64'd2);

        // 4: second done edge mid-line
        applyReset();
        applyStimulus(2'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                      32'h55555555, 32'h66666666, 16'h7777);
        done = 1'b1;
        fork
            rxLine(line, startCyc);
            begin
                repeat (1000) @(negedge sysclk);
                done = 1'b0;
                @(negedge sysclk);
                applyStimulus(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0);
                done = 1'b1;
                @(negedge sysclk);
                checkOutput("overrun_set", 64'(overrun), 64'd1);
                done = 1'b0;
            end
        join
        waitBusyLow(fallCyc);
        checkLine("line_overrun_intact", line, line4);
        countTxLow(500, lows);
        checkOutput("no_line_after_overrun", 64'(lows), 64'd0);
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);
        checkOutput("frames_after_overrun", 64'(frames_sent), 64'd1);

        // 5: done held high gives a single report
        applyReset();
        applyStimulus(2'd2, 32'h00000010, 32'h00000020, 32'h0000000F, 32'hDEADBEEF,
                      32'h12345678, 32'h0000ABCD, 16'h0400);
        raiseCyc = cyc;
        done = 1'b1;
        rxLine(line, startCyc);
        waitBusyLow(fallCyc);
        checkLine("line_held_done", line, line2);
        n = 20000 - (cyc - raiseCyc);
        countTxLow(n, lows);
        checkOutput("held_done_single_line", 64'(lows), 64'd0);
        checkOutput("frames_held_done", 64'(frames_sent), 64'd1);
        done = 1'b0;
        repeat (2) @(negedge sysclk);
        done = 1'b1;
        rxLine(line, startCyc);
        waitBusyLow(fallCyc);
        checkLine("line_second_edge", line, line2);
        checkOutput("frames_second_edge", 64'(frames_sent), 64'd2);

        // 6: reset during char 40
        done = 1'b0;
        applyStimulus(2'd1, 32'h00000000, 32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567,
                      32'hA5A5A5A5, 32'h00000001, 16'hFFFF);
        repeat (2) @(negedge sysclk);
        done = 1'b1;
        n = 0;
        @(negedge sysclk);
        while (uart_tx !== 1'b0 && n < 1000) begin
            @(negedge sysclk);
            n++;
        end
        repeat (40 * (10 * DIV + 2) + 3) @(negedge sysclk);
        checkOutput("pre_reset_tx_low", 64'(uart_tx), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_tx_high", 64'(uart_tx), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_overrun", 64'(overrun), 64'd0);
        checkOutput("reset_frames", 64'(frames_sent), 64'd0);
        done = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        done = 1'b1;
        rxLine(line, startCyc);
        waitBusyLow(fallCyc);
        checkOutput("restart_prefix", 64'(line.substr(0, 1) == "W="), 64'd1);
        checkLine("line_after_reset", line, line3);
        checkOutput("frames_after_reset_line", 64'(frames_sent), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
